// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the CPU memory/IO export port between instruction fetch (IF) and
//   the data stage (D). Each access keeps bus_en high for MEM_LAT cycles.
//   The requester then gets a one-cycle done pulse, and read data is held on
//   rdata. D has priority. IF is guaranteed the next arbitration after it
//   has lost STARVE_LIM contested arbitrations in a row.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   if_req, if_addr               fetch request (read-only, memory space)
//   if_gnt, if_done               IF owns the bus / fetch complete pulse
//   d_req, d_rw, d_memio,
//   d_addr, d_wdata               data-stage request and command
//   d_gnt, d_done                 D owns the bus / data access complete pulse
//   rdata                         last read data returned
//   bus_en, bus_rw, bus_memio,
//   bus_addr, bus_wdata           command toward the export port
//   bus_rdata                     read data from the export port
//   busy                          arbiter not idle
module mem_bus_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_gnt,
  output logic        if_done,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic        d_memio,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_gnt,
  output logic        d_done,
  output logic [15:0] rdata,
  output logic        bus_en,
  output logic        bus_rw,
  output logic        bus_memio,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_wdata,
  input  logic [15:0] bus_rdata,
  output logic        busy
);

  localparam int DATA_W = 16;
  localparam int CNT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STV_W  = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [STV_W-1:0] starve, starve_nxt;
  logic             owner_d, owner_d_nxt;  // 1: D owns the bus, 0: IF
  logic             load;                  // latch the winner's command
  logic             capture;               // sample bus_rdata into rdata

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      starve  <= '0;
      owner_d <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      starve  <= starve_nxt;
      owner_d <= owner_d_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    starve_nxt  = starve;
    owner_d_nxt = owner_d;
    load        = 1'b0;
    capture     = 1'b0;
    bus_en      = 1'b0;
    busy        = 1'b0;
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;
    if_done     = 1'b0;
    d_done      = 1'b0;

    case (state)
      IDLE: begin
        if (if_req || d_req) begin
          load      = 1'b1;
          cnt_nxt   = CNT_W'(MEM_LAT - 1);
          state_nxt = BUSY;
          if (if_req && d_req) begin
            // Contested: D wins unless IF has lost STARVE_LIM times in a row.
            // starve < STARVE_LIM in the D branch, so the increment saturates.
            if (starve == STV_W'(STARVE_LIM)) begin
              owner_d_nxt = 1'b0;
              starve_nxt  = '0;
            end else begin
              owner_d_nxt = 1'b1;
              starve_nxt  = starve + STV_W'(1);
            end
          end else if (d_req) begin
            owner_d_nxt = 1'b1;
          end else begin
            owner_d_nxt = 1'b0;
            starve_nxt  = '0;
          end
        end
      end
      BUSY: begin
        bus_en = 1'b1;
        busy   = 1'b1;
        if_gnt = ~owner_d;
        d_gnt  = owner_d;
        if (cnt == '0) begin
          capture   = ~bus_rw;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        busy      = 1'b1;
        if_gnt    = ~owner_d;
        d_gnt     = owner_d;
        if_done   = ~owner_d;
        d_done    = owner_d;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus command and read-data registers. They are reset so that every
  // output is zero after reset; a reset mid-access also discards the
  // pending read.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_rw    <= 1'b0;
      bus_memio <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rdata     <= '0;
    end else begin
      if (load) begin
        if (owner_d_nxt) begin
          bus_rw    <= d_rw;
          bus_memio <= d_memio;
          bus_addr  <= d_addr;
          bus_wdata <= d_wdata;
        end else begin
          bus_rw    <= 1'b0;
          bus_memio <= 1'b0;
          bus_addr  <= if_addr;
          bus_wdata <= {DATA_W{1'b0}};
        end
      end
      if (capture) begin
        rdata <= bus_rdata;
      end
    end
  end

endmodule
